// File: rtl/tdc_result_uart_tx.sv
// tdc_result_uart_tx: receives 40-bit TDC result words and buffers them in a small FIFO.
// Each word is sent over UART 8N1 as a 6-byte packet: {SYNC_BYTE, word[39:0]}, MSB byte first.
module tdc_result_uart_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter logic [3:0]  MARKER       = 4'b0101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [39:0] data_in,
  input  logic        valid_in,
  input  logic        clear_err,
  output logic        tx,
  output logic        busy,
  output logic        overflow,
  output logic        marker_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [47:0]   shift_reg;
  logic [6:0]    cur_byte;     // bits of the current byte not yet driven onto tx

  logic [39:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [NW-1:0] count;

  logic          bit_end;
  logic          pkt_end;
  logic          pop;
  logic          push;
  logic          marker_ok;
  logic          drop_marker;
  logic          drop_full;
  logic          next_active;
  logic [NW-1:0] count_next;

  // Push/pop decisions; a pop frees a slot in the same cycle, so a full FIFO can still accept.
  always_comb begin
    bit_end     = (clk_cnt == BIT_LAST);
    pkt_end     = (state == STOP) && bit_end && (byte_idx == 3'd5);
    pop         = (count != '0) && ((state == IDLE) || pkt_end);
    marker_ok   = (data_in[3:0] == MARKER);
    drop_marker = valid_in && !marker_ok;
    drop_full   = valid_in && marker_ok && (count == FULL_CNT) && !pop;
    push        = valid_in && marker_ok && !drop_full;
    count_next  = count + NW'(push) - NW'(pop);
    next_active = (state == IDLE) ? pop : !(pkt_end && !pop);
  end

  // FIFO storage: plain array without reset so it maps onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers, occupancy and the sticky error flags (an error event beats clear_err).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      marker_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_next;

      if (drop_full) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end

      if (drop_marker) begin
        marker_err <= 1'b1;
      end else if (clear_err) begin
        marker_err <= 1'b0;
      end
    end
  end

  // UART framing FSM with registered tx and busy; packets chain without an idle bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
      cur_byte  <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      busy <= next_active || (count_next != '0);
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift_reg <= {SYNC_BYTE, mem[rd_ptr]};
            byte_idx  <= 3'd0;
            clk_cnt   <= '0;
            tx        <= 1'b0;
            state     <= START;
          end
        end

        START: begin
          if (bit_end) begin
            clk_cnt   <= '0;
            bit_idx   <= 3'd0;
            tx        <= shift_reg[40];
            cur_byte  <= shift_reg[47:41];
            shift_reg <= {shift_reg[39:0], 8'h00};
            state     <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              tx       <= cur_byte[0];
              cur_byte <= {1'b0, cur_byte[6:1]};
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (byte_idx != 3'd5) begin
              byte_idx <= byte_idx + 3'd1;
              tx       <= 1'b0;
              state    <= START;
            end else if (pop) begin
              shift_reg <= {SYNC_BYTE, mem[rd_ptr]};
              byte_idx  <= 3'd0;
              tx        <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
